// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader
//
// Loads operands for a small ALU from four slide switches using a single
// push button. Each debounced press advances a four-step sequence:
//   S_A   : press captures sw[N-1:0] into A
//   S_B   : press captures sw[N-1:0] into B
//   S_OP  : press captures sw[3:0] into ALUControl and pulses op_valid
//   S_RUN : press returns to S_A (operands hold their values)
//
// The raw button passes through a two-flop synchronizer and then a
// counter-based debouncer. Only a debounced rising edge produces a press.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   sw[3:0]     slide switches (quasi-static data)
//   btn_next    raw, bouncy, asynchronous push button (active-high)
//   clr         synchronous clear (clean, active-high)
//   A[N-1:0]    registered operand A
//   B[N-1:0]    registered operand B
//   ALUControl  registered operation code
//   op_valid    one-cycle pulse marking a complete, fresh operand set
//   phase[1:0]  current FSM state encoding (display / debug visibility)
//
// op_valid semantics: a single-cycle strobe with no back-pressure. It is
// high for exactly the cycle after the S_OP -> S_RUN transition, at which
// point A, B and ALUControl all hold the freshly captured set. There is no
// ready input; a consumer that misses the strobe simply misses it.
// ---------------------------------------------------------------------------
module alu_operand_loader #(
    parameter int N               = 3,  // operand width, 1..4
    parameter int DEBOUNCE_CYCLES = 4   // stable cycles to accept a change, >= 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   sw,
    input  logic         btn_next,
    input  logic         clr,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [3:0]   ALUControl,
    output logic         op_valid,
    output logic [1:0]   phase
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RUN = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer and debouncer
    // ------------------------------------------------------------------
    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;
    logic          press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= btn_next;
            s2       <= s1;
            stable_d <= stable;
            if (s2 != stable) begin
                // The counter reaching CNT_LAST means s2 has already
                // disagreed for DEBOUNCE_CYCLES-1 edges; this edge is the
                // DEBOUNCE_CYCLES-th, so accept the new level.
                if (cnt == CNT_LAST) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // One-cycle event in the cycle after stable rises; releases are silent.
    assign press = stable & ~stable_d;

    // ------------------------------------------------------------------
    // Operand FSM
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_next;
    logic [N-1:0]  b_next;
    logic [3:0]    alu_next;
    logic          op_valid_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_A;
            A          <= '0;
            B          <= '0;
            ALUControl <= '0;
            op_valid   <= 1'b0;
        end else begin
            state      <= state_next;
            A          <= a_next;
            B          <= b_next;
            ALUControl <= alu_next;
            op_valid   <= op_valid_next;
        end
    end

    always_comb begin
        state_next    = state;
        a_next        = A;
        b_next        = B;
        alu_next      = ALUControl;
        op_valid_next = 1'b0;

        // clr has priority; a press arriving in the same cycle is dropped.
        if (clr) begin
            state_next = S_A;
            a_next     = '0;
            b_next     = '0;
            alu_next   = '0;
        end else if (press) begin
            case (state)
                S_A: begin
                    a_next     = sw[N-1:0];
                    state_next = S_B;
                end
                S_B: begin
                    b_next     = sw[N-1:0];
                    state_next = S_OP;
                end
                S_OP: begin
                    alu_next      = sw;
                    op_valid_next = 1'b1;
                    state_next    = S_RUN;
                end
                S_RUN: begin
                    state_next = S_A;
                end
                default: begin
                    state_next = S_A;
                end
            endcase
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_loader
//
// Directed bench for alu_operand_loader (N=3, DEBOUNCE_CYCLES=4).
// A behavioural model tracks the button as seen two edges late, measures
// how long it has disagreed with the accepted level, and advances a simple
// phase counter on each accepted press. A compare process checks every
// output against the model on each falling edge; the directed sequence adds
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_alu_operand_loader;

  localparam int N  = 3;
  localparam int DB = 4;

  // --------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   sw = 4'h0;
  logic         btn_next = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   ALUControl;
  logic         op_valid;
  logic [1:0]   phase;

  always #5 clk = ~clk;

  alu_operand_loader #(.N(N), .DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .btn_next   (btn_next),
    .clr        (clr),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .op_valid   (op_valid),
    .phase      (phase)
  );

  // --------------------------------------------------------------------
  // Scoreboard counters
  // --------------------------------------------------------------------
  int n_total = 0;
  int n_pass  = 0;
  int opv_count = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------
  int m_seen1 = 0, m_seen2 = 0;   // button samples from one and two edges ago
  int m_level = 0;                // accepted button level
  int m_run   = 0;                // consecutive edges the seen level disagreed
  int m_pend  = 0;                // accepted rise waiting to act next edge
  int m_phase = 0, m_a = 0, m_b = 0, m_alu = 0, m_opv = 0;
  int m_seen, m_press;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_seen1 = 0; m_seen2 = 0; m_level = 0; m_run = 0; m_pend = 0;
      m_phase = 0; m_a = 0; m_b = 0; m_alu = 0; m_opv = 0;
    end else begin
      m_press = m_pend;
      m_pend  = 0;
      m_seen  = m_seen2;
      m_seen2 = m_seen1;
      m_seen1 = int'(btn_next);
      if (m_seen != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level = m_seen;
          m_run   = 0;
          if (m_level == 1) m_pend = 1;
        end
      end else begin
        m_run = 0;
      end
      m_opv = 0;
      if (clr) begin
        m_phase = 0; m_a = 0; m_b = 0; m_alu = 0;
      end else if (m_press == 1) begin
        if (m_phase == 0) m_a = int'(sw) % (1 << N);
        else if (m_phase == 1) m_b = int'(sw) % (1 << N);
        else if (m_phase == 2) begin m_alu = int'(sw); m_opv = 1; end
        m_phase = (m_phase + 1) % 4;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("cyc_A", int'(A), m_a);
    check("cyc_B", int'(B), m_b);
    check("cyc_alu", int'(ALUControl), m_alu);
    check("cyc_opv", int'(op_valid), m_opv);
    check("cyc_phase", int'(phase), m_phase);
    if (op_valid) opv_count++;
  end

  // --------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------
  task automatic press_btn(input logic [3:0] v);
    @(negedge clk);
    sw = v;
    btn_next = 1'b1;
    repeat (10) @(negedge clk);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // --------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------
  int opv_base;

  initial begin
    // Reset held across several edges.
    repeat (3) @(negedge clk);
    check("rst_A", int'(A), 0);
    check("rst_B", int'(B), 0);
    check("rst_alu", int'(ALUControl), 0);
    check("rst_opv", int'(op_valid), 0);
    check("rst_phase", int'(phase), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full sequence: 5, 2, 2.
    opv_base = opv_count;
    press_btn(4'h5);
    check("seq_phase1", int'(phase), 1);
    press_btn(4'h2);
    press_btn(4'h2);
    check("seq_A", int'(A), 5);
    check("seq_B", int'(B), 2);
    check("seq_alu", int'(ALUControl), 2);
    check("seq_phase", int'(phase), 3);
    check("seq_opv_pulses", opv_count - opv_base, 1);

    // S_RUN press returns to S_A and holds operands.
    press_btn(4'hF);
    check("run_phase", int'(phase), 0);
    check("run_A_hold", int'(A), 5);
    check("run_alu_hold", int'(ALUControl), 2);

    // Latency: first sample at edge k, FSM moves at edge k+6, not earlier.
    @(negedge clk);
    sw = 4'h3;
    btn_next = 1'b1;
    @(posedge clk);                 // edge k
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 6) check("lat_early", int'(phase), 0);
      else check("lat_edge", int'(phase), 1);
    end
    btn_next = 1'b0;
    repeat (10) @(negedge clk);
    check("lat_A", int'(A), 3);

    // Bounce: 3-cycle pulses never qualify.
    pulse_clr();
    check("clr_phase", int'(phase), 0);
    check("clr_A", int'(A), 0);
    sw = 4'h7;
    for (int r = 0; r < 5; r++) begin
      btn_next = 1'b1;
      repeat (3) @(negedge clk);
      btn_next = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("bounce_phase", int'(phase), 0);
    check("bounce_A", int'(A), 0);

    // Hold for 50 cycles: exactly one advance; upper switch bit masked.
    sw = 4'hD;
    btn_next = 1'b1;
    repeat (50) @(negedge clk);
    check("hold_phase", int'(phase), 1);
    check("hold_A_masked", int'(A), 5);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);

    // Reach S_OP, then clr in the same cycle as the press.
    press_btn(4'h6);
    check("pre_clr_phase", int'(phase), 2);
    opv_base = opv_count;
    @(negedge clk);
    sw = 4'h9;
    btn_next = 1'b1;
    @(posedge clk);                 // edge k
    repeat (5) @(posedge clk);      // press is high in the following cycle
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clrpress_phase", int'(phase), 0);
    check("clrpress_A", int'(A), 0);
    check("clrpress_B", int'(B), 0);
    check("clrpress_alu", int'(ALUControl), 0);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);
    check("clrpress_no_opv", opv_count - opv_base, 0);
    check("clrpress_still0", int'(phase), 0);

    // Reach S_RUN with A=5, then reset asynchronously between edges.
    press_btn(4'h5);
    press_btn(4'h1);
    press_btn(4'h4);
    check("prerst_phase", int'(phase), 3);
    check("prerst_A", int'(A), 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_A", int'(A), 0);
    check("async_B", int'(B), 0);
    check("async_alu", int'(ALUControl), 0);
    check("async_opv", int'(op_valid), 0);
    check("async_phase", int'(phase), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset mid-debounce: the press restarts from scratch afterwards.
    sw = 4'h2;
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("scratch_early", int'(phase), 0);
    repeat (8) @(negedge clk);
    check("scratch_phase", int'(phase), 1);
    check("scratch_A", int'(A), 2);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter N, default 3, legal range 1..4: operand width in bits, matching the ALU width.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, minimum 2: consecutive stable cycles required to accept a button level change.
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sw  input  4  slide switches, treated as quasi-static data.
REQ-007 btn_next  input  1  raw push button, active-high, asynchronous and bouncy.
REQ-008 clr  input  1  synchronous clear, active-high, already clean and synchronous to clk.
REQ-009 A  output  N  registered operand A.
REQ-010 B  output  N  registered operand B.
REQ-011 ALUControl  output  4  registered operation code.
REQ-012 op_valid  output  1  one-cycle pulse marking a complete, fresh operand set.
REQ-013 phase  output  2  current FSM state encoding, for display.

Function
REQ-014 btn_next SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-015 Debouncer: counter increments each edge while s2 != stable and clears each edge while s2 == stable.
REQ-016 Debouncer: when the counter equals DEBOUNCE_CYCLES-1 and s2 != stable, stable <= s2 and the counter clears on that edge.
REQ-017 press SHALL be asserted combinationally for exactly one cycle, in the cycle after stable rises 0->1; a falling edge of stable produces no event.
REQ-018 FSM states: S_A=2'b00, S_B=2'b01, S_OP=2'b10, S_RUN=2'b11; phase SHALL equal the current state.
REQ-019 S_A + press: A <= sw[N-1:0], next state S_B.
REQ-020 S_B + press: B <= sw[N-1:0], next state S_OP.
REQ-021 S_OP + press: ALUControl <= sw[3:0], next state S_RUN, op_valid <= 1 on the same edge.
REQ-022 S_RUN + press: next state S_A; A, B and ALUControl SHALL hold their values.
REQ-023 op_valid SHALL be registered, high for exactly one cycle after the S_OP->S_RUN edge, and low at all other times.
REQ-024 A, B and ALUControl SHALL change only on their own capture edge or on clear.
REQ-025 clr SHALL force state S_A, A=0, B=0, ALUControl=0 and op_valid=0 on the next edge from any state.
REQ-026 If clr and press occur in the same cycle, clr SHALL win and the press is discarded.
REQ-027 Latency: for btn_next first sampled high at edge k and held, stable rises at edge k+1+DEBOUNCE_CYCLES and the FSM updates at edge k+2+DEBOUNCE_CYCLES.
REQ-028 Any bounce shorter than DEBOUNCE_CYCLES cycles (measured at s2) SHALL produce no press.
REQ-029 A button held indefinitely SHALL produce exactly one press; the next press requires a debounced release followed by a debounced press.
REQ-030 When N<4, sw[3:N] SHALL be ignored for operand capture.

Reset
REQ-031 While rst_n=0, the following SHALL hold immediately, independent of clk: state=S_A, A=0, B=0, ALUControl=0, op_valid=0, s1=s2=0, stable=0, counter=0.
REQ-032 Reset asserted mid-debounce or in S_RUN SHALL discard all partial progress; the first press after release SHALL be debounced from scratch.

Verification (N=3, DEBOUNCE_CYCLES=4)
REQ-033 Full sequence: sw=4'h5 press, sw=4'h2 press, sw=4'h2 press -> A=5, B=2, ALUControl=2, phase=3, exactly one op_valid pulse.
REQ-034 Latency: btn_next first sampled high at edge 10 and held -> phase changes at edge 16 and not earlier.
REQ-035 Bounce: btn_next high for 3 cycles then low, repeated 5 times -> phase stays 0 and no register changes.
REQ-036 Hold: btn_next high for 50 cycles in S_A -> exactly one advance to phase=1.
REQ-037 clr and press in the same cycle while in S_OP -> phase=0, all outputs 0, no op_valid pulse.
REQ-038 rst_n pulsed low asynchronously, between edges, while in S_RUN with A=5 -> all outputs 0 before the next clk edge.
